// File: rtl/subleq_mem.sv
// subleq_mem: 256 x 8 memory wrapper for a SUBLEQ core with a byte loader,
// a cycle-budgeted run phase and a side inspection (dump) port.
//
// state | meaning
// ------+----------------------------------------------------------------
// LOAD  | loader bytes written to memory[load_ptr], load_ptr increments
// RUN   | core owns memory: registered read + unconditional write each cycle
// DONE  | budget exhausted; memory frozen until reset
//
// Ports:
//   clock, reset             sole clock; synchronous active-high reset
//   load_valid/data/last     loader byte stream; load_ready high in LOAD
//   run_cycles [CNT_W]       RUN budget, latched on LOAD->RUN
//   read [8], write [16]     core read address; write = {value, address}
//   data [8]                 registered memory[read], 1-cycle latency
//   core_run, done           state decodes
//   cycle_count [CNT_W]      RUN cycles executed
//   dump_addr [8]            inspection address
//   dump_data [8]            registered memory[dump_addr], read-before-write
//
// Build option: define SUBLEQ_MEM_BYPASS_EN to forward the RUN write value
// to data when read and write addresses collide (default: read-before-write).

module subleq_mem #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [7:0]       read,
  input  logic [15:0]      write,
  output logic [7:0]       data,
  output logic             core_run,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  input  logic [7:0]       dump_addr,
  output logic [7:0]       dump_data
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [7:0]       mem [256];
  logic [7:0]       load_ptr;
  logic [CNT_W-1:0] budget;
  logic [CNT_W-1:0] count_inc;

  logic       load_fire;
  logic       run_write;
  logic       mem_we;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  assign load_fire = (state == LOAD) && load_valid;
  // A zero budget still spends one RUN cycle but must not touch memory.
  assign run_write = (state == RUN) && (budget != '0);
  // Reset blocks the write of the cycle in which it is asserted.
  assign mem_we    = !reset && (load_fire || run_write);
  assign wr_addr   = load_fire ? load_ptr  : write[7:0];
  assign wr_data   = load_fire ? load_data : write[15:8];
  assign count_inc = cycle_count + ONE;

  assign load_ready = (state == LOAD);
  assign core_run   = (state == RUN);
  assign done       = (state == DONE);

  // Memory has no reset so contents survive across runs.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= LOAD;
      load_ptr    <= 8'h00;
      cycle_count <= '0;
      budget      <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            load_ptr <= load_ptr + 8'h01;
            // Leaving at 0xFF keeps the wrapped pointer from writing again.
            if (load_last || (load_ptr == 8'hFF)) begin
              state       <= RUN;
              budget      <= run_cycles;
              cycle_count <= '0;
            end
          end
        end
        RUN: begin
          if (budget == '0) begin
            state <= DONE;
          end else begin
            cycle_count <= count_inc;
            if (count_inc == budget) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data      <= 8'h00;
      dump_data <= 8'h00;
    end else begin
      dump_data <= mem[dump_addr];
      if (state == RUN) begin
`ifdef SUBLEQ_MEM_BYPASS_EN
        if (run_write && (read == write[7:0])) begin
          data <= write[15:8];
        end else begin
          data <= mem[read];
        end
`else
        data <= mem[read];
`endif
      end
    end
  end

endmodule

// File: tb/tb_subleq_mem.sv
// Directed, self-checking bench for subleq_mem. Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_subleq_mem;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_last;
  logic             load_ready;
  logic [CNT_W-1:0] run_cycles;
  logic [7:0]       read;
  logic [15:0]      write;
  logic [7:0]       data;
  logic             core_run;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  logic [7:0]       dump_addr;
  logic [7:0]       dump_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } dump_vec_t;

  dump_vec_t small_tbl [13];
  dump_vec_t full_tbl  [3];

  subleq_mem #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .run_cycles  (run_cycles),
    .read        (read),
    .write       (write),
    .data        (data),
    .core_run    (core_run),
    .done        (done),
    .cycle_count (cycle_count),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic dump_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
    dump_addr = addr;
    step();
    check(name, {24'h0, dump_data}, {24'h0, exp});
  endtask

  // Bytes base+0 .. base+n-1, load_last on the final one.
  task automatic load_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + 8'(i);
      load_last  = (i == n - 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      small_tbl[i].addr = 8'(i);
      small_tbl[i].exp  = 8'(i);
    end
    small_tbl[12].addr = 8'h30;
    small_tbl[12].exp  = 8'h30;
    full_tbl[0] = '{addr: 8'h00, exp: 8'h5A};
    full_tbl[1] = '{addr: 8'hFF, exp: 8'hA5};
    full_tbl[2] = '{addr: 8'h80, exp: 8'hDA};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    run_cycles = '0;
    read       = 8'h00;
    write      = 16'h0000;
    dump_addr  = 8'h00;

    // ---- reset state, 12-byte load, budget 4 ----
    do_reset();
    check("rst load_ready", {31'h0, load_ready}, 32'd1);
    check("rst core_run", {31'h0, core_run}, 32'd0);
    check("rst done", {31'h0, done}, 32'd0);
    check("rst data", {24'h0, data}, 32'h0);
    check("rst dump_data", {24'h0, dump_data}, 32'h0);
    check("rst cycle_count", {16'h0, cycle_count}, 32'd0);

    run_cycles = 16'd4;
    read       = 8'h05;
    write      = 16'h3030;
    load_bytes(12, 8'h00);
    check("ld12 load_ready", {31'h0, load_ready}, 32'd0);
    check("ld12 core_run", {31'h0, core_run}, 32'd1);
    check("ld12 cycle_count", {16'h0, cycle_count}, 32'd0);
    step();
    check("run1 data", {24'h0, data}, 32'h05);
    check("run1 cycle_count", {16'h0, cycle_count}, 32'd1);
    step();
    step();
    check("run3 done", {31'h0, done}, 32'd0);
    step();
    check("run4 done", {31'h0, done}, 32'd1);
    check("run4 core_run", {31'h0, core_run}, 32'd0);
    check("run4 cycle_count", {16'h0, cycle_count}, 32'd4);

    // In DONE: write bus and loader ignored, data holds.
    write      = 16'h5500;
    read       = 8'h01;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    foreach (small_tbl[i]) begin
      dump_check($sformatf("dump12 addr 0x%02h", small_tbl[i].addr),
                 small_tbl[i].addr, small_tbl[i].exp);
    end
    check("done data hold", {24'h0, data}, 32'h05);
    check("done persists", {31'h0, done}, 32'd1);
    load_valid = 1'b0;

    // ---- collision and budget 10 ----
    do_reset();
    check("rst2 data", {24'h0, data}, 32'h0);
    check("rst2 cycle_count", {16'h0, cycle_count}, 32'd0);
    run_cycles = 16'd10;
    read       = 8'h04;
    write      = 16'h7704;    // ignored while loading
    load_bytes(5, 8'hA0);     // wrong data for addr 4 ...
    do_reset();               // ... so reload with 0x11 at addr 4
    load_valid = 1'b1; load_data = 8'hA0; step();
    load_data = 8'hA1; step();
    load_data = 8'hA2; step();
    load_data = 8'hA3; step();
    load_data = 8'h11; load_last = 1'b1; step();
    load_valid = 1'b0; load_last = 1'b0;
    check("ld5 core_run", {31'h0, core_run}, 32'd1);
    step();
`ifdef SUBLEQ_MEM_BYPASS_EN
    check("collide 0x04", {24'h0, data}, 32'h77);
`else
    check("collide 0x04", {24'h0, data}, 32'h11);
`endif
    read  = 8'h03;
    write = 16'h2A03;
    step();
`ifdef SUBLEQ_MEM_BYPASS_EN
    check("collide 0x03", {24'h0, data}, 32'h2A);
`else
    check("collide 0x03", {24'h0, data}, 32'hA3);
`endif
    step();
    check("post-write 0x03", {24'h0, data}, 32'h2A);
    for (int c = 4; c <= 10; c++) begin
      step();
      check($sformatf("b10 done @%0d", c), {31'h0, done}, {31'h0, c == 10});
    end
    check("b10 cycle_count", {16'h0, cycle_count}, 32'd10);
    write = 16'h6603;
    dump_check("b10 mem 0x03", 8'h03, 8'h2A);
    dump_check("b10 mem 0x04", 8'h04, 8'h77);
    dump_check("b10 mem 0x02", 8'h02, 8'hA2);

    // ---- reset during RUN ----
    do_reset();
    run_cycles = 16'd100;
    read       = 8'h02;
    write      = 16'h0140;
    load_bytes(8, 8'h10);
    step();
    check("mid data", {24'h0, data}, 32'h12);
    step(); step(); step();
    check("mid cycle_count", {16'h0, cycle_count}, 32'd4);
    write = 16'h9907;
    reset = 1'b1;
    step();
    check("midrst core_run", {31'h0, core_run}, 32'd0);
    check("midrst load_ready", {31'h0, load_ready}, 32'd1);
    check("midrst data", {24'h0, data}, 32'h0);
    check("midrst cycle_count", {16'h0, cycle_count}, 32'd0);
    reset = 1'b0;
    dump_check("midrst mem 0x07", 8'h07, 8'h17);

    // ---- zero budget ----
    do_reset();
    run_cycles = 16'd0;
    write      = 16'h5501;
    load_bytes(2, 8'h21);
    check("b0 core_run", {31'h0, core_run}, 32'd1);
    step();
    check("b0 done", {31'h0, done}, 32'd1);
    check("b0 cycle_count", {16'h0, cycle_count}, 32'd0);
    dump_check("b0 mem 0x01", 8'h01, 8'h22);

    // ---- 256-byte load without load_last ----
    do_reset();
    run_cycles = 16'd1;
    write      = 16'hDA80;    // rewrites the value already loaded at 0x80
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i) ^ 8'h5A;
      load_last  = 1'b0;
      step();
      if (i == 254) check("ld255 core_run", {31'h0, core_run}, 32'd0);
    end
    check("ld256 core_run", {31'h0, core_run}, 32'd1);
    load_data = 8'hEE;        // held valid: must not wrap into addr 0
    step();
    check("ld256 done", {31'h0, done}, 32'd1);
    check("ld256 cycle_count", {16'h0, cycle_count}, 32'd1);
    foreach (full_tbl[i]) begin
      dump_check($sformatf("dump256 addr 0x%02h", full_tbl[i].addr),
                 full_tbl[i].addr, full_tbl[i].exp);
    end
    load_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/subleq_mem.md
SUBLEQ_MEM -- requirements
Module: subleq_mem

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the run-cycle budget and cycle counter.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port load_valid  in  1  loader byte valid.
REQ-005 SHALL have port load_data  in  8  loader byte.
REQ-006 SHALL have port load_last  in  1  marks final loader byte.
REQ-007 SHALL have port load_ready  out  1  loader byte accepted when high with load_valid.
REQ-008 SHALL have port run_cycles  in  CNT_W  core cycle budget, sampled on LOAD->RUN.
REQ-009 SHALL have port read  in  8  core read address.
REQ-010 SHALL have port write  in  16  core write bus: [15:8] value, [7:0] address.
REQ-011 SHALL have port data  out  8  registered read data to core.
REQ-012 SHALL have port core_run  out  1  high while in RUN.
REQ-013 SHALL have port done  out  1  high while in DONE.
REQ-014 SHALL have port cycle_count  out  CNT_W  RUN cycles executed.
REQ-015 SHALL have port dump_addr  in  8  inspection address.
REQ-016 SHALL have port dump_data  out  8  registered memory[dump_addr].

Function
REQ-017 SHALL contain a 256 x 8 memory; its contents SHALL NOT be cleared by reset.
REQ-018 SHALL implement states LOAD, RUN, DONE; LOAD after reset.
REQ-019 In LOAD, load_ready SHALL be 1; each accepted byte SHALL be written to memory[load_ptr], then load_ptr incremented (8-bit).
REQ-020 LOAD->RUN SHALL occur on the cycle after an accepted byte with load_last=1 or load_ptr=0xFF; load_ptr SHALL NOT wrap into further writes.
REQ-021 On LOAD->RUN, run_cycles SHALL be latched and cycle_count cleared; a latched budget of 0 SHALL go directly to DONE after one RUN cycle with no memory write.
REQ-022 In RUN, every cycle SHALL register data <= memory[read] and write memory[write[7:0]] <= write[15:8]; no write enable exists.
REQ-023 Read latency SHALL be exactly 1 cycle from read address to data.
REQ-024 In RUN, cycle_count SHALL increment each cycle; the cycle where cycle_count+1 equals the budget SHALL be the last RUN cycle, then DONE.
REQ-025 Outside RUN, the write bus SHALL be ignored and data SHALL hold its value.
REQ-026 In LOAD or DONE, load_valid outside LOAD SHALL be ignored; DONE SHALL persist until reset.
REQ-027 dump_data SHALL be memory[dump_addr] registered, 1-cycle latency, valid in all states; on same-cycle write to dump_addr it SHALL return the pre-write value.
REQ-028 core_run and done SHALL be decoded from the state register (glitch-free, registered).

Reset
REQ-029 On reset: state=LOAD, load_ptr=0, cycle_count=0, data=0x00, dump_data=0x00, core_run=0, done=0, load_ready=1 on the following cycle.
REQ-030 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation that cycle; that cycle's write SHALL NOT occur; memory SHALL keep prior contents.

Configuration
REQ-031 Macro SUBLEQ_MEM_BYPASS_EN SHALL control RUN read/write collision.
REQ-032 With SUBLEQ_MEM_BYPASS_EN defined, read==write[7:0] in the same RUN cycle SHALL give data = write[15:8].
REQ-033 Without it, the same collision SHALL give data = pre-write memory value (read-before-write).

Verification
REQ-034 Reset, load 12 bytes 0x00..0x0B with load_last on the 12th -> load_ready drops, core_run=1 next cycle, dump of 0x05 returns 0x05.
REQ-035 Load 256 bytes without load_last -> RUN after byte 0xFF; memory[0xFF] correct; memory[0x00] not overwritten.
REQ-036 Budget 10, RUN with read=0x03, write=0x2A03 each cycle -> cycle_count reaches 10, done=1, memory[0x03]=0x2A, further writes ignored.
REQ-037 Collision read=0x04 (holding 0x11), write=0x7704 -> data=0x77 with BYPASS_EN, 0x11 without.
REQ-038 Reset asserted at RUN cycle 5 with write=0x9907 -> state LOAD, data=0x00, memory[0x07] unchanged.
REQ-039 run_cycles=0 -> one RUN cycle, no memory write, then done=1, cycle_count=0.
